// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage for the sequential CPU.
// Owns the PC and issues one word fetch per cycle to a synchronous
// instruction memory with 1-cycle read latency. Returned words are tagged
// with their fetch address and buffered in a small FIFO, then handed to
// decode over a valid/ready handshake. A redirect flushes the buffer and
// discards the response still in flight, then restarts fetch at the new PC.
module pc_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 'h28,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_ins,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pcp4
);

    localparam int unsigned      PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned      CNT_W     = PTR_W + 1;
    localparam logic [XLEN-1:0]  INS_BYTES = XLEN'(4);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FIFO_DEPTH);
    localparam logic [XLEN-1:0]  PC_START  = {RESET_PC[XLEN-1:2], 2'b00};

    // Fetch-side state
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  tag;
    logic             inflight;

    // Instruction buffer
    logic [XLEN-1:0]  buf_ins [FIFO_DEPTH];
    logic [XLEN-1:0]  buf_pc  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Per-cycle control
    logic [CNT_W-1:0] occupancy;
    logic             fifo_nonempty;
    logic             issue;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  redirect_aligned;

    assign fifo_nonempty    = (count != '0);
    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    // Issue/push/pop decisions. Occupancy uses the registered count so a pop
    // in this cycle never frees a slot for an issue in the same cycle; the
    // in-flight word always has a reserved slot, so a push is never dropped.
    always_comb begin
        occupancy = count + {{(CNT_W-1){1'b0}}, inflight};
        issue     = rst_n && !redirect_valid && (occupancy < CNT_MAX);
        push      = inflight && !redirect_valid;
        pop       = fifo_nonempty && out_ready && !redirect_valid;
    end

    assign imem_req  = issue;
    assign imem_addr = pc;

    // Head of the buffer is presented directly; outputs read zero while empty
    // so a flushed entry can never leak onto out_pc.
    assign out_valid = fifo_nonempty;
    assign out_ins   = fifo_nonempty ? buf_ins[rd_ptr] : '0;
    assign out_pc    = fifo_nonempty ? buf_pc[rd_ptr] : '0;
    assign out_pcp4  = fifo_nonempty ? (buf_pc[rd_ptr] + INS_BYTES) : '0;

    // PC, in-flight flag and fetch tag; redirect overrides any issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= PC_START;
            tag      <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_aligned;
            inflight <= 1'b0;
        end else if (issue) begin
            pc       <= pc + INS_BYTES;
            tag      <= pc;
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    // Buffer pointers and occupancy count; a redirect empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage: capture the returned word together with its fetch address.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_ins[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]  <= tag;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit. The reference model is
// the architectural rule that the delivered stream is the consecutive word
// sequence starting at the last reset/redirect target; a second instance runs
// with a reset PC near the top of the address space to exercise wrap-around.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        imem_req, redirect_valid, out_valid, out_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_ins, out_pc, out_pcp4;

    logic        imem_req2, out_valid2;
    logic [31:0] imem_addr2, imem_rdata2, out_ins2, out_pc2, out_pcp42;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2    = 32'h0;
    logic        out_ready2      = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h28), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ins(out_ins), .out_pc(out_pc), .out_pcp4(out_pcp4)
    );

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_ins(out_ins2), .out_pc(out_pc2), .out_pcp4(out_pcp42)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory models: word = {A5A5, addr[15:0]} of the previous accepted request
    logic        req_s, req_s2;
    logic [31:0] addr_s, addr_s2;
    initial begin
        imem_rdata  = 32'h0;
        imem_rdata2 = 32'h0;
    end
    always @(negedge clk) begin
        req_s   = imem_req;
        addr_s  = imem_addr;
        req_s2  = imem_req2;
        addr_s2 = imem_addr2;
    end
    always @(posedge clk) begin
        if (req_s)  imem_rdata  <= {16'hA5A5, addr_s[15:0]};
        if (req_s2) imem_rdata2 <= {16'hA5A5, addr_s2[15:0]};
    end

    // Expected-stream queues, refilled by the stimulus side
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] gen1, gen2;
    int          hs1 = 0;
    int          hs2 = 0;

    task automatic topup();
        while (q1.size() < 8) begin q1.push_back(gen1); gen1 = gen1 + 32'd4; end
        while (q2.size() < 8) begin q2.push_back(gen2); gen2 = gen2 + 32'd4; end
    endtask

    task automatic restart1(input logic [31:0] a);
        q1.delete();
        gen1 = {a[31:2], 2'b00};
        topup();
    endtask

    task automatic restart2(input logic [31:0] a);
        q2.delete();
        gen2 = {a[31:2], 2'b00};
        topup();
    endtask

    // Monitor for dut: handshakes, hold behaviour and outstanding-fetch bound
    logic [31:0] e1, hold_pc;
    logic        hold_prev = 1'b0;
    int          outst = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            outst     = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_pc", out_pc, hold_pc);
            end
            if (out_valid && out_ready && !redirect_valid) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb1_empty: got pc %h expected no output", out_pc);
                end else begin
                    e1 = q1.pop_front();
                    chk("sb1_pc", out_pc, e1);
                    chk("sb1_ins", out_ins, {16'hA5A5, e1[15:0]});
                    chk("sb1_pcp4", out_pcp4, e1 + 32'd4);
                    hs1++;
                end
            end
            if (redirect_valid) begin
                outst = 0;
            end else begin
                outst = outst + int'(imem_req) - int'(out_valid && out_ready);
                chk("outstanding_le_depth", 32'(outst > 4), 32'd0);
            end
            hold_prev = out_valid && !out_ready && !redirect_valid;
            hold_pc   = out_pc;
        end
    end

    // Monitor for dut2 (always ready, never redirected)
    logic [31:0] e2;
    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb2_empty: got pc %h expected no output", out_pc2);
            end else begin
                e2 = q2.pop_front();
                chk("sb2_pc", out_pc2, e2);
                chk("sb2_ins", out_ins2, {16'hA5A5, e2[15:0]});
                chk("sb2_pcp4", out_pcp42, e2 + 32'd4);
                hs2++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        topup();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        restart1(32'h28);
        restart2(32'hFFFF_FFF8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    int n_issue;
    int h0;
    int since;
    logic rd;

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        do_reset();

        // Reset state
        repeat (2) cyc();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ins", out_ins, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_pcp4", out_pcp4, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h28);
        chk("rst_imem_addr2", imem_addr2, 32'hFFFF_FFF8);
        chk("rst_out_valid2", 32'(out_valid2), 32'd0);

        // 1: release with out_ready=1, sequential stream at one per cycle
        rst_n = 1'b1;
        #1;
        chk("t1_first_req", 32'(imem_req), 32'd1);
        cyc();
        chk("t1_valid_e1", 32'(out_valid), 32'd0);
        chk("t1_addr_e1", imem_addr, 32'h2C);
        cyc();
        chk("t1_valid_e2", 32'(out_valid), 32'd1);
        chk("t1_pc_e2", out_pc, 32'h28);
        chk("t1_ins_e2", out_ins, 32'hA5A5_0028);
        chk("t5_pc2_first", out_pc2, 32'hFFFF_FFF8);
        h0 = hs1;
        for (int i = 0; i < 11; i++) begin
            cyc();
            chk("t1_throughput_valid", 32'(out_valid), 32'd1);
            if (i == 0) begin
                chk("t5_pc2_second", out_pc2, 32'hFFFF_FFFC);
                chk("t5_pcp4_wrap", out_pcp42, 32'h0);
            end
            if (i == 1) begin
                chk("t5_pc2_third", out_pc2, 32'h0);
                chk("t5_ins2_third", out_ins2, 32'hA5A5_0000);
            end
        end
        chk("t1_handshakes", 32'(hs1 - h0), 32'd11);

        // 2: backpressure from reset, buffer fills to depth and holds
        do_reset();
        out_ready = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        #1;
        n_issue = 0;
        for (int i = 0; i < 10; i++) begin
            n_issue += int'(imem_req);
            cyc();
        end
        chk("t2_issues_when_full", 32'(n_issue), 32'd4);
        chk("t2_req_low", 32'(imem_req), 32'd0);
        chk("t2_addr", imem_addr, 32'h38);
        chk("t2_hold_valid", 32'(out_valid), 32'd1);
        chk("t2_hold_pc", out_pc, 32'h28);
        chk("t2_hold_ins", out_ins, 32'hA5A5_0028);
        h0 = hs1;
        out_ready = 1'b1;
        repeat (5) cyc();
        chk("t2_drain_count", 32'(hs1 - h0), 32'd5);

        // 3: redirect while buffer holds 0x30..0x3C
        do_reset();
        out_ready = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (6) cyc();
        out_ready = 1'b1;
        repeat (2) cyc();
        out_ready = 1'b0;
        repeat (6) cyc();
        chk("t3_head_before", out_pc, 32'h30);
        chk("t3_req_full", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        restart1(32'h103);
        #1;
        chk("t3_no_issue_on_redirect", 32'(imem_req), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        chk("t3_valid_r1", 32'(out_valid), 32'd0);
        chk("t3_new_addr", imem_addr, 32'h100);
        chk("t3_new_req", 32'(imem_req), 32'd1);
        cyc();
        chk("t3_valid_r2", 32'(out_valid), 32'd0);
        cyc();
        chk("t3_valid_r3", 32'(out_valid), 32'd1);
        chk("t3_pc_r3", out_pc, 32'h100);

        // 4: redirect coinciding with a return and a pop, then back-to-back redirects
        repeat (6) cyc();
        chk("t4_stream_req", 32'(imem_req), 32'd1);
        cyc();
        chk("t4_stream_valid", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000_0041;
        restart1(32'h2000_0041);
        cyc();
        redirect_valid = 1'b0;
        chk("t4_valid_r1", 32'(out_valid), 32'd0);
        cyc();
        chk("t4_valid_r2", 32'(out_valid), 32'd0);
        cyc();
        chk("t4_pc_r3", out_pc, 32'h2000_0040);
        repeat (3) cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        restart1(32'h500);
        cyc();
        redirect_pc = 32'h777;
        restart1(32'h777);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("t4_b2b_addr", imem_addr, 32'h774);
        repeat (2) cyc();
        chk("t4_b2b_pc", out_pc, 32'h774);

        // 6: asynchronous reset mid-stream
        repeat (4) cyc();
        #2;
        do_reset();
        #1;
        chk("t6_req_immediate", 32'(imem_req), 32'd0);
        chk("t6_valid_immediate", 32'(out_valid), 32'd0);
        chk("t6_pc_immediate", out_pc, 32'h0);
        chk("t6_addr_immediate", imem_addr, 32'h28);
        cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("t6_restart_pc", out_pc, 32'h28);

        // Random phase: random backpressure and redirects
        since = 0;
        for (int i = 0; i < 1500; i++) begin
            rd             = ($urandom_range(0, 19) == 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = rd;
            if (rd) begin
                redirect_pc = $urandom;
                restart1(redirect_pc);
            end
            cyc();
            if (rd) since = 1;
            else if (since > 0) since++;
            if (since == 1 || since == 2) chk("rnd_redirect_bubble", 32'(out_valid), 32'd0);
            else if (since == 3) chk("rnd_redirect_latency", 32'(out_valid), 32'd1);
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (4) cyc();
        chk("total_hs1_enough", 32'(hs1 >= 300), 32'd1);
        chk("total_hs2_enough", 32'(hs2 >= 1000), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
